// File: rtl/pma_region_scanner_if.sv
// Request/response handshake between a PMA requester (master) and the scanner (slave).
interface pma_region_scanner_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_exec_o;
    logic              rsp_cached_o;
    logic              rsp_nonidem_o;

    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_exec_o, rsp_cached_o, rsp_nonidem_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_exec_o, rsp_cached_o, rsp_nonidem_o
    );
endinterface

// File: rtl/pma_region_scanner.sv
// Iterative PMA lookup: one rule index per cycle across the execute, cached and
// non-idempotent tables, with sticky per-class hit flags and a registered response.

module pma_rule_match #(
    parameter int ADDR_W = 64
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              hit
);
    // One extra bit so a region ending exactly at 2^ADDR_W does not wrap to zero.
    logic [ADDR_W:0] region_end;

    assign region_end = {1'b0, base} + {1'b0, len};
    assign hit = en && (len != '0) && (addr >= base) && ({1'b0, addr} < region_end);
endmodule

module pma_region_scanner #(
    parameter int NR_MAX = 16,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = $clog2(NR_MAX + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CNT_W-1:0]       exec_nr_i,
    input  logic [NR_MAX*64-1:0]   exec_base_i,
    input  logic [NR_MAX*64-1:0]   exec_len_i,
    input  logic [CNT_W-1:0]       cached_nr_i,
    input  logic [NR_MAX*64-1:0]   cached_base_i,
    input  logic [NR_MAX*64-1:0]   cached_len_i,
    input  logic [CNT_W-1:0]       nonidem_nr_i,
    input  logic [NR_MAX*64-1:0]   nonidem_base_i,
    input  logic [NR_MAX*64-1:0]   nonidem_len_i,
    input  logic                   kill_i,
    pma_region_scanner_if.slave    bus
);
    localparam int NUM_CLS = 3;
    localparam int IDX_W   = (NR_MAX > 1) ? $clog2(NR_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                                     state;
    logic [CNT_W-1:0]                           idx;
    logic [CNT_W-1:0]                           scan_len;
    logic [IDX_W-1:0]                           idx_sel;
    logic [ADDR_W-1:0]                          addr_q;
    logic [NUM_CLS-1:0]                         flags;
    logic [NUM_CLS-1:0]                         hits;
    logic                                       rsp_valid_q;
    logic [NUM_CLS-1:0][CNT_W-1:0]              nr_raw;
    logic [NUM_CLS-1:0][CNT_W-1:0]              nr_clamp;
    logic [NUM_CLS-1:0][NR_MAX-1:0][ADDR_W-1:0] base_tbl;
    logic [NUM_CLS-1:0][NR_MAX-1:0][ADDR_W-1:0] len_tbl;

    // Class order everywhere: 0 = execute, 1 = cached, 2 = non-idempotent.
    assign nr_raw[0]   = exec_nr_i;
    assign nr_raw[1]   = cached_nr_i;
    assign nr_raw[2]   = nonidem_nr_i;
    assign base_tbl[0] = exec_base_i;
    assign base_tbl[1] = cached_base_i;
    assign base_tbl[2] = nonidem_base_i;
    assign len_tbl[0]  = exec_len_i;
    assign len_tbl[1]  = cached_len_i;
    assign len_tbl[2]  = nonidem_len_i;

    // idx never exceeds NR_MAX-1 while scanning, so the low bits select the rule.
    assign idx_sel = idx[IDX_W-1:0];

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
        assign nr_clamp[c] = (nr_raw[c] > CNT_W'(NR_MAX)) ? CNT_W'(NR_MAX) : nr_raw[c];

        pma_rule_match #(.ADDR_W(ADDR_W)) u_match (
            .en   (idx < nr_clamp[c]),
            .addr (addr_q),
            .base (base_tbl[c][idx_sel]),
            .len  (len_tbl[c][idx_sel]),
            .hit  (hits[c])
        );
    end

    always_comb begin
        scan_len = nr_clamp[0];
        if (nr_clamp[1] > scan_len) scan_len = nr_clamp[1];
        if (nr_clamp[2] > scan_len) scan_len = nr_clamp[2];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            addr_q      <= '0;
            flags       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i && !kill_i) begin
                        addr_q <= bus.req_addr_i;
                        flags  <= '0;
                        idx    <= '0;
                        if (scan_len != '0) begin
                            state <= SCAN;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (kill_i) begin
                        state <= IDLE;
                        flags <= '0;
                        idx   <= '0;
                    end else begin
                        flags <= flags | hits;
                        if (idx == scan_len - CNT_W'(1)) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                RESP: begin
                    // Kill wins over a same-cycle handshake: the response is dropped.
                    if (kill_i || bus.rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        flags       <= '0;
                        idx         <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    flags       <= '0;
                    idx         <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready_o   = (state == IDLE);
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_exec_o    = flags[0];
    assign bus.rsp_cached_o  = flags[1];
    assign bus.rsp_nonidem_o = flags[2];
endmodule

// File: tb/tb_pma_region_scanner.sv
// Directed bench for pma_region_scanner: latency, region boundaries, backpressure, kill, reset.
module tb_pma_region_scanner;
    localparam int NR_MAX = 16;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = $clog2(NR_MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 kill = 1'b0;
    logic [CNT_W-1:0]     exec_nr, cached_nr, nonidem_nr;
    logic [NR_MAX*64-1:0] exec_base, exec_len, cached_base, cached_len, nonidem_base, nonidem_len;
    logic [2:0]           attr;
    int                   n_chk = 0;
    int                   n_err = 0;

    pma_region_scanner_if #(.ADDR_W(ADDR_W)) bus ();

    pma_region_scanner #(.NR_MAX(NR_MAX), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .exec_nr_i      (exec_nr),
        .exec_base_i    (exec_base),
        .exec_len_i     (exec_len),
        .cached_nr_i    (cached_nr),
        .cached_base_i  (cached_base),
        .cached_len_i   (cached_len),
        .nonidem_nr_i   (nonidem_nr),
        .nonidem_base_i (nonidem_base),
        .nonidem_len_i  (nonidem_len),
        .kill_i         (kill),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // attr = {exec, cached, nonidem}
    assign attr = {bus.rsp_exec_o, bus.rsp_cached_o, bus.rsp_nonidem_o};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        exec_nr = '0; cached_nr = '0; nonidem_nr = '0;
        exec_base = '0; exec_len = '0; cached_base = '0; cached_len = '0;
        nonidem_base = '0; nonidem_len = '0;
    endtask

    task automatic set_rule(input int cls, input int k, input logic [63:0] b, input logic [63:0] l);
        case (cls)
            0: begin exec_base[k*64 +: 64] = b;    exec_len[k*64 +: 64] = l;    end
            1: begin cached_base[k*64 +: 64] = b;  cached_len[k*64 +: 64] = l;  end
            default: begin nonidem_base[k*64 +: 64] = b; nonidem_len[k*64 +: 64] = l; end
        endcase
    endtask

    task automatic cfg_a();
        clear_cfg();
        exec_nr = 3; cached_nr = 1; nonidem_nr = 2;
        set_rule(0, 0, 64'h8000_0000, 64'h4000_0000);
        set_rule(0, 1, 64'h1_0000, 64'h1_0000);
        set_rule(0, 2, 64'h0, 64'h1000);
        set_rule(1, 0, 64'h8000_0000, 64'h4000_0000);
        set_rule(2, 0, 64'h8000_0000, 64'h0);
        set_rule(2, 1, 64'h0, 64'h0);
    endtask

    // Returns the cycle (relative to the accepting edge) at which rsp_valid is first seen.
    task automatic send_req(input logic [63:0] a, output int lat);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.rsp_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [63:0] a, input int exp_lat, input logic [2:0] exp_attr);
        int lat;
        chk({tag, "/ready"}, 64'(bus.req_ready_o), 64'd1);
        send_req(a, lat);
        chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/attr"}, 64'(attr), 64'(exp_attr));
        ack();
    endtask

    initial begin
        int lat;
        int seen;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.rsp_ready_i = 1'b0;
        clear_cfg();

        repeat (2) @(negedge clk);
        chk("reset/state", {59'd0, bus.req_ready_o, bus.rsp_valid_o, attr}, 64'b1_0_000);
        rst = 1'b0;

        // Mixed three-class configuration, scan_len = 3 -> latency 4
        cfg_a();
        lookup("a_inside",   64'h8000_1000, 4, 3'b110);
        lookup("a_top",      64'hBFFF_FFFF, 4, 3'b110);
        lookup("a_past_top", 64'hC000_0000, 4, 3'b000);
        lookup("a_low",      64'h0FFF,      4, 3'b100);
        lookup("a_r1_last",  64'h1_FFFF,    4, 3'b100);
        lookup("a_r1_end",   64'h2_0000,    4, 3'b000);

        // Region ending at 2^64 must not wrap
        clear_cfg();
        exec_nr = 1;
        set_rule(0, 0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000);
        lookup("w_in",    64'hFFFF_FFFF_FFFF_FFF0, 2, 3'b100);
        lookup("w_max",   64'hFFFF_FFFF_FFFF_FFFF, 2, 3'b100);
        lookup("w_zero",  64'h0,                   2, 3'b000);
        lookup("w_below", 64'hFFFF_FFFF_FFFF_EFFF, 2, 3'b000);

        // Empty tables -> immediate response
        clear_cfg();
        lookup("empty", 64'h8000_0000, 1, 3'b000);

        // Count above NR_MAX clamps to NR_MAX; last rule index still scanned
        clear_cfg();
        exec_nr = 20; nonidem_nr = 4;
        set_rule(0, 15, 64'h5000, 64'h100);
        set_rule(2, 3,  64'h5000, 64'h10);
        lookup("clamp_both", 64'h500F, 17, 3'b101);
        lookup("clamp_edge", 64'h5010, 17, 3'b100);

        // Backpressure: response held stable, no new request accepted
        cfg_a();
        send_req(64'h8000_1000, lat);
        chk("bp/lat", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp/hold%0d", i), {59'd0, bus.rsp_valid_o, bus.req_ready_o, attr}, 64'b1_0_110);
        end
        ack();
        chk("bp/released", {62'd0, bus.rsp_valid_o, bus.req_ready_o}, 64'b01);
        lookup("bp_next", 64'hC000_0000, 4, 3'b000);

        // Kill during the second scan cycle: no response ever appears
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h8000_1000;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_scan/state", {59'd0, bus.req_ready_o, bus.rsp_valid_o, attr}, 64'b1_0_000);
        seen = 0;
        repeat (6) begin @(negedge clk); if (bus.rsp_valid_o) seen++; end
        chk("kill_scan/no_rsp", 64'(seen), 64'd0);

        // Kill in IDLE blocks a same-cycle request
        @(negedge clk);
        kill = 1'b1; bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h8000_1000;
        @(negedge clk);
        kill = 1'b0; bus.req_valid_i = 1'b0;
        chk("kill_idle/ready", 64'(bus.req_ready_o), 64'd1);
        seen = 0;
        repeat (5) begin @(negedge clk); if (bus.rsp_valid_o) seen++; end
        chk("kill_idle/no_rsp", 64'(seen), 64'd0);

        // Reset mid-scan after a flag has already been set
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 64'h8000_1000;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_scan/partial", {59'd0, bus.req_ready_o, bus.rsp_valid_o, attr}, 64'b0_0_110);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_scan/state", {59'd0, bus.req_ready_o, bus.rsp_valid_o, attr}, 64'b1_0_000);

        // Kill together with rsp_ready in RESP drops the response
        send_req(64'h8000_1000, lat);
        chk("kill_rsp/lat", 64'(lat), 64'd4);
        kill = 1'b1; bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        kill = 1'b0; bus.rsp_ready_i = 1'b0;
        chk("kill_rsp/state", {59'd0, bus.req_ready_o, bus.rsp_valid_o, attr}, 64'b1_0_000);
        lookup("after_kill", 64'h0FFF, 4, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
